// File: rtl/vin_ps2_ctrl.sv
// PS/2 host controller: filtered bus receive, E0/F0 scancode decode, optional host transmit.
// Define VIN_PS2_CTRL_TX_EN to build the host-to-device transmit path; otherwise the TX outputs are tied low.
module vin_ps2_ctrl #(
    parameter int CLK_FREQ   = 48000000,
    parameter int TIMEOUT_US = 2000,
    parameter int INHIBIT_US = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_release,
    output logic        key_valid,
    output logic [15:0] code,
    output logic        rx_err,
    input  logic [7:0]  tx_data,
    input  logic        tx_req,
    output logic        tx_busy,
    output logic        tx_err
);
    localparam int          CYC_PER_US  = CLK_FREQ / 1000000;
    localparam logic [31:0] TIMEOUT_CYC = 32'(CYC_PER_US * TIMEOUT_US);
    localparam logic [31:0] INHIBIT_CYC = 32'(CYC_PER_US * INHIBIT_US);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [1:0]  clk_sync, data_sync;
    logic [2:0]  clk_samp, data_samp;
    logic        clk_filt_q, clk_filt, data_filt, fall;
    logic [31:0] gap_cnt;
    logic        gap_timeout, rx_waiting, tx_waiting;
    rx_state_t   rx_state;
    logic [7:0]  rx_shift;
    logic [2:0]  bit_cnt;
    logic        par_ok, ext_pend, rel_pend;

    // Synchronizers and filters idle high, matching a released bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_samp   <= 3'b111;
            data_samp  <= 3'b111;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            data_sync  <= {data_sync[0], ps2_data_in};
            clk_samp   <= {clk_samp[1:0], clk_sync[1]};
            data_samp  <= {data_samp[1:0], data_sync[1]};
            clk_filt_q <= clk_filt;
        end
    end

    assign clk_filt  = (clk_samp[0] & clk_samp[1]) | (clk_samp[0] & clk_samp[2]) | (clk_samp[1] & clk_samp[2]);
    assign data_filt = (data_samp[0] & data_samp[1]) | (data_samp[0] & data_samp[2]) | (data_samp[1] & data_samp[2]);
    assign fall      = clk_filt_q & ~clk_filt;

    // One gap counter serves both directions; it only runs while a frame is in flight.
    assign gap_timeout = (gap_cnt == TIMEOUT_CYC - 32'd1);
    assign rx_waiting  = (rx_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset || fall || !(rx_waiting || tx_waiting)) begin
            gap_cnt <= 32'd0;
        end else if (!gap_timeout) begin
            gap_cnt <= gap_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= IDLE;
            rx_shift    <= 8'h00;
            bit_cnt     <= 3'd0;
            par_ok      <= 1'b0;
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
            code        <= 16'h0000;
            rx_err      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            rx_err    <= 1'b0;
            if (tx_busy) begin
                rx_state <= IDLE;
            end else if (fall) begin
                case (rx_state)
                    IDLE: begin
                        if (!data_filt) begin
                            rx_state <= DATA;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    DATA: begin
                        rx_shift <= {data_filt, rx_shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok   <= ^{rx_shift, data_filt};
                        rx_state <= STOP;
                    end
                    default: begin
                        rx_state <= IDLE;
                        if (data_filt && par_ok) begin
                            code <= {code[7:0], rx_shift};
                            if (rx_shift == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (rx_shift == 8'hF0) begin
                                rel_pend <= 1'b1;
                            end else begin
                                key_code    <= rx_shift;
                                key_ext     <= ext_pend;
                                key_release <= rel_pend;
                                key_valid   <= 1'b1;
                                ext_pend    <= 1'b0;
                                rel_pend    <= 1'b0;
                            end
                        end else begin
                            rx_err   <= 1'b1;
                            ext_pend <= 1'b0;
                            rel_pend <= 1'b0;
                        end
                    end
                endcase
            end else if (gap_timeout && rx_waiting) begin
                rx_state <= IDLE;
                rx_err   <= 1'b1;
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end
        end
    end

`ifdef VIN_PS2_CTRL_TX_EN
    typedef enum logic [1:0] {TX_IDLE, TX_INHIBIT, TX_BITS} tx_state_t;

    tx_state_t   tx_state;
    logic [7:0]  tx_byte;
    logic [3:0]  tx_idx;
    logic [31:0] inh_cnt;
    logic        tx_pend;

    assign tx_waiting = (tx_state == TX_BITS);

    // A request is latched immediately but only launched once the receiver is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            tx_byte     <= 8'h00;
            tx_idx      <= 4'd0;
            inh_cnt     <= 32'd0;
            tx_pend     <= 1'b0;
            tx_busy     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_err <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pend && rx_state == IDLE) begin
                        tx_pend    <= 1'b0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= 32'd0;
                        tx_state   <= TX_INHIBIT;
                    end else if (tx_req && !tx_pend) begin
                        tx_pend <= 1'b1;
                        tx_byte <= tx_data;
                    end
                end
                TX_INHIBIT: begin
                    if (inh_cnt == INHIBIT_CYC - 32'd1) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        tx_idx      <= 4'd0;
                        tx_state    <= TX_BITS;
                    end else begin
                        inh_cnt <= inh_cnt + 32'd1;
                    end
                end
                default: begin
                    if (fall) begin
                        tx_idx <= tx_idx + 4'd1;
                        if (tx_idx < 4'd8) begin
                            ps2_data_oe <= ~tx_byte[tx_idx[2:0]];
                        end else if (tx_idx == 4'd8) begin
                            ps2_data_oe <= ^tx_byte;
                        end else if (tx_idx == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                        end else begin
                            tx_busy  <= 1'b0;
                            tx_err   <= data_filt;
                            tx_state <= TX_IDLE;
                        end
                    end else if (gap_timeout) begin
                        tx_busy     <= 1'b0;
                        tx_err      <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_state    <= TX_IDLE;
                    end
                end
            endcase
        end
    end
`else
    logic unused_tx;

    assign unused_tx   = ^{tx_data, tx_req, INHIBIT_CYC};
    assign tx_waiting  = 1'b0;
    assign tx_busy     = 1'b0;
    assign tx_err      = 1'b0;
    assign ps2_clk_oe  = 1'b0;
    assign ps2_data_oe = 1'b0;
`endif

endmodule

// File: tb/tb_vin_ps2_ctrl.sv
// Self-checking bench for vin_ps2_ctrl: byte-level scancode model plus hand-computed frame expectations.
// Covers the transmit handshake when VIN_PS2_CTRL_TX_EN is defined, the tied-off TX ports otherwise.
`timescale 1ns/1ps
module tb_vin_ps2_ctrl;
    localparam int CLK_FREQ   = 1000000;
    localparam int TIMEOUT_US = 300;
    localparam int INHIBIT_US = 20;
    localparam int HALF       = 20;

    typedef struct packed {
        logic [7:0] kc;
        logic       ext;
        logic       rel;
    } key_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_oe, ps2_data_oe;
    logic [7:0]  key_code;
    logic        key_ext, key_release, key_valid;
    logic [15:0] code;
    logic        rx_err;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_req = 1'b0;
    logic        tx_busy, tx_err;

    key_t        exp_keys[$];
    key_t        got_key;
    int          exp_errs = 0;
    logic [15:0] exp_code = 16'h0000;
    logic [15:0] next_code = 16'h0000;
    logic        m_ext = 1'b0, m_rel = 1'b0;
    bit          settled = 0;
    int          checks = 0, errors = 0;
    int          tx_err_seen = 0;

    vin_ps2_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_US(TIMEOUT_US),
        .INHIBIT_US(INHIBIT_US)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .key_valid  (key_valid),
        .code       (code),
        .rx_err     (rx_err),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_busy    (tx_busy),
        .tx_err     (tx_err)
    );

    // Open-collector bus: either side pulling low wins.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_errs++;
            m_ext = 1'b0;
            m_rel = 1'b0;
            return;
        end
        next_code = {next_code[7:0], b};
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            exp_keys.push_back({b, m_ext, m_rel});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_keys.delete();
        exp_errs  = 0;
        next_code = 16'h0000;
        m_ext     = 1'b0;
        m_rel     = 1'b0;
    endfunction

    task automatic settle_check();
        exp_code = next_code;
        checkOutput("strobes_outstanding", exp_keys.size() + exp_errs, 0);
        exp_keys.delete();
        exp_errs = 0;
        settled  = 1;
    endtask

    task automatic ps2_bit(input logic b);
        dev_data = b;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic par_flip, input logic stop);
        logic par;
        par     = ~^b ^ par_flip;
        settled = 0;
        model_byte(b, !par_flip && stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        dev_data = 1'b1;
        repeat (HALF) @(negedge clk);
        settle_check();
    endtask

    task automatic check_reset_values(input string name);
        checkOutput(name, {key_code, code, key_ext, key_release, key_valid, rx_err,
                           tx_busy, tx_err, ps2_clk_oe, ps2_data_oe}, 32'h0);
    endtask

    task automatic tx_transfer(input logic [7:0] b, input logic ack);
        int         n;
        logic [9:0] line_bits;
        tx_data = b;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        for (int i = 0; i < 50 && !ps2_clk_oe; i++) @(negedge clk);
        checkOutput("tx_inhibit_start", ps2_clk_oe, 1);
        checkOutput("tx_busy_start", tx_busy, 1);
        n = 0;
        while (ps2_clk_oe && n < 10 * INHIBIT_US) begin
            n++;
            @(negedge clk);
        end
        checkOutput("tx_inhibit_len_ok", n >= INHIBIT_US * (CLK_FREQ / 1000000), 1);
        checkOutput("tx_start_bit", ps2_data_in, 0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            line_bits[i] = ps2_data_in;
            repeat (HALF) @(negedge clk);
        end
        checkOutput("tx_line_bits", line_bits, {1'b1, ~^b, b});
        dev_data = ack;
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
        checkOutput("tx_busy_end", tx_busy, 0);
    endtask

    // Compare process: every strobe must match the model, and code is checked whenever no frame is in flight.
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin
                checkOutput("key_valid_expected", key_valid, exp_keys.size() != 0);
                if (exp_keys.size() != 0) begin
                    got_key = exp_keys.pop_front();
                    checkOutput("key_code", key_code, got_key.kc);
                    checkOutput("key_ext", key_ext, got_key.ext);
                    checkOutput("key_release", key_release, got_key.rel);
                end
            end
            if (rx_err) begin
                checkOutput("rx_err_expected", rx_err, exp_errs != 0);
                if (exp_errs != 0) exp_errs--;
            end
            if (settled) checkOutput("code", code, exp_code);
            if (tx_err) tx_err_seen++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        settled = 1;

        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("make_1c", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b0, 16'h001C});

        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("break_1c", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b1, 16'hF01C});

        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("ext_break_75", {key_code, key_ext, key_release, code}, {8'h75, 1'b1, 1'b1, 16'hF075});
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flags_cleared", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b0, 16'h751C});

        applyStimulus(8'h1C, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("code_after_errors", code, 16'h751C);

        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1C, 1'b1, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("error_clears_prefix", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b0, 16'hF01C});

        applyStimulus(8'hE0, 1'b0, 1'b1);
        settled = 0;
        model_byte(8'h00, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (TIMEOUT_US * (CLK_FREQ / 1000000) + 60) @(negedge clk);
        settle_check();
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("after_timeout", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b0, 16'hE01C});

        settled = 0;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_midframe");
        reset = 1'b0;
        model_reset();
        settle_check();
        repeat (HALF) @(negedge clk);
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("after_reset", {key_code, key_ext, key_release, code}, {8'h1C, 1'b0, 1'b0, 16'h001C});

`ifdef VIN_PS2_CTRL_TX_EN
        tx_transfer(8'hED, 1'b0);
        checkOutput("tx_ack0_err", tx_err_seen, 0);
        repeat (HALF) @(negedge clk);
        tx_transfer(8'hED, 1'b1);
        checkOutput("tx_ack1_err", tx_err_seen, 1);
        applyStimulus(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rx_after_tx", {key_code, code}, {8'h1C, 16'h1C1C});
`else
        tx_data = 8'hED;
        tx_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge clk);
            checkOutput("tx_tied_off", {tx_busy, tx_err, ps2_clk_oe, ps2_data_oe}, 0);
        end
        tx_req = 1'b0;
`endif

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vin_ps2_ctrl.md
VIN_PS2_CTRL -- requirements
Module: vin_ps2_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 48000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between PS/2 clock falling edges inside one frame.
REQ-003 SHALL have parameter INHIBIT_US, default 100, host clock-inhibit time before transmit.
REQ-004 SHALL have port clk, input, 1, system clock; the block uses this single clock only.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports ps2_clk_in and ps2_data_in, input, 1 each, raw asynchronous bus levels.
REQ-007 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each; 1 means drive the open-collector line low.
REQ-008 SHALL have port key_code, output, 8, last decoded scancode.
REQ-009 SHALL have ports key_ext and key_release, output, 1 each, E0 and F0 prefix flags for key_code.
REQ-010 SHALL have port key_valid, output, 1, one-cycle strobe qualifying key_code, key_ext and key_release.
REQ-011 SHALL have port code, output, 16, the last two good raw bytes, newest in [7:0].
REQ-012 SHALL have port rx_err, output, 1, one-cycle strobe on a framing, parity or timeout error.
REQ-013 SHALL have ports tx_data (input, 8), tx_req (input, 1), tx_busy (output, 1) and tx_err (output, 1, one-cycle strobe).

Function
REQ-014 SHALL pass both bus inputs through 2-FF synchronizers, then through a 3-sample majority filter.
REQ-015 SHALL detect falling edges of the filtered PS/2 clock; all bit sampling occurs on the detect cycle.
REQ-016 RX FSM SHALL use states IDLE, DATA, PARITY and STOP.
- IDLE: start bit 0 moves to DATA; start bit 1 is ignored.
- DATA: 8 bits, LSB first.
- PARITY: odd parity is checked.
- STOP: stop bit must be 1.
REQ-017 A parity or stop error SHALL pulse rx_err, discard the byte, clear the prefix flags and return the FSM to IDLE.
REQ-018 If no falling edge occurs for TIMEOUT_US while the FSM is not IDLE, the FSM SHALL return to IDLE, pulse rx_err and clear the prefix flags.
REQ-019 Each good byte SHALL shift into code: code[15:8] takes the old code[7:0], and code[7:0] takes the new byte.
REQ-020 Decoder behaviour for each good byte:
- 0xE0 sets the pending ext flag.
- 0xF0 sets the pending release flag.
- Any other byte drives key_code, key_ext and key_release, pulses key_valid for 1 cycle, then clears both pending flags.
REQ-021 key_valid and code update SHALL occur exactly 1 clk after the stop-bit edge-detect cycle.
REQ-022 Prefix bytes SHALL NOT pulse key_valid.

Reset
REQ-023 Reset SHALL take effect on the next clk edge regardless of FSM state, including mid-frame and mid-transmit.
REQ-024 Reset values SHALL be:
- key_code=0x00, code=0x0000.
- key_ext, key_release, key_valid, rx_err, tx_busy, tx_err = 0.
- ps2_clk_oe = ps2_data_oe = 0.
- Both FSMs in IDLE, pending flags clear.

Configuration
REQ-025 Macro VIN_PS2_CTRL_TX_EN SHALL enable host-to-device transmit.
REQ-026 With VIN_PS2_CTRL_TX_EN defined, the TX sequence SHALL be:
- tx_req is accepted only when tx_busy=0 and the RX FSM is in IDLE; a request during RX is held until RX returns to IDLE.
- On accept, tx_busy=1 and ps2_clk_oe=1 for INHIBIT_US.
- Then ps2_data_oe=1 (start bit) and ps2_clk_oe=0.
- On each device falling edge, drive the next bit: 8 data bits LSB first, then odd parity, then release (stop bit).
- On the next falling edge, sample the ack bit; the expected value is 0.
- tx_busy=0 after the ack bit.
- tx_err SHALL pulse if the ack bit is 1 or the TIMEOUT_US gap expires.
- tx_req while tx_busy=1 is ignored.
- RX decoding is suppressed while tx_busy=1.
REQ-027 Without VIN_PS2_CTRL_TX_EN, the TX ports SHALL remain present:
- tx_busy, tx_err, ps2_clk_oe and ps2_data_oe are tied to 0.
- tx_data and tx_req are ignored.

Verification
REQ-028 Device frame 0x1C (parity 0, stop 1) -> key_valid pulse, key_code=0x1C, key_ext=0, key_release=0, code=0x001C.
REQ-029 Frames F0, 1C -> one key_valid with key_code=0x1C, key_release=1, code=0xF01C; no strobe for F0.
REQ-030 Frames E0, F0, 75 -> one key_valid with key_code=0x75, key_ext=1, key_release=1; the next frame 0x1C gives both flags 0.
REQ-031 Frame 0x1C with wrong parity -> rx_err pulse, no key_valid, code unchanged; frame stopped after 4 bits for more than TIMEOUT_US -> rx_err pulse, FSM in IDLE.
REQ-032 TX_EN, tx_data=0xED, device acks with 0 -> clock inhibit for at least INHIBIT_US, line bits 0 (start), 0xED LSB first, parity 1, then tx_busy falls with no tx_err; with ack 1 -> tx_err pulse.
REQ-033 Reset asserted mid-frame after 5 bits -> all outputs at reset values next cycle; a following clean frame 0x1C decodes correctly.
